// File: rtl/ps2_pkg.sv
// Shared PS/2 Set-2 definitions: prefix bytes, ignored controller responses, receiver state type.
package ps2_pkg;

    typedef logic [7:0] scan_code_t;

    localparam scan_code_t PS2_BREAK = 8'hF0;
    localparam scan_code_t PS2_EXT   = 8'hE0;

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} ps2_rx_state_t;

    // Keyboard status/ack bytes that arrive in the stream but are not keys.
    function automatic logic isIgnored(input scan_code_t code);
        return code inside {8'h00, 8'hAA, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
    endfunction

endpackage

// File: rtl/key_slot_table.sv
// Press-ordered held-key table: add without duplicates, remove with shift-down compaction,
// sticky overflow that clears once the table empties.
module key_slot_table
    import ps2_pkg::*;
#(
    parameter int unsigned MAX_KEYS = 2
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       addEn,
    input  logic       removeEn,
    input  logic       clearEn,
    input  scan_code_t code,
    output logic [2:0] keyCount,
    output scan_code_t keyCode1,
    output scan_code_t keyCode2,
    output logic       overflow
);

    localparam logic [2:0] MaxCount = 3'(MAX_KEYS);

    scan_code_t slotQ [MAX_KEYS];
    scan_code_t slotD [MAX_KEYS];
    scan_code_t extSlots [MAX_KEYS + 1];
    logic [2:0] countQ, countD;
    logic       ovfQ, ovfD;
    logic [MAX_KEYS-1:0] hitVec;
    logic       hit, full, below;

    always_comb begin
        for (int i = 0; i < MAX_KEYS; i++) begin
            extSlots[i] = slotQ[i];
            hitVec[i]   = (3'(i) < countQ) && (slotQ[i] == code);
        end
        extSlots[MAX_KEYS] = 8'h00;
        hit  = |hitVec;
        full = (countQ == MaxCount);

        slotD  = slotQ;
        countD = countQ;
        ovfD   = ovfQ;
        below  = 1'b0;

        if (clearEn) begin
            for (int i = 0; i < MAX_KEYS; i++) slotD[i] = 8'h00;
            countD = 3'd0;
            ovfD   = 1'b0;
        end else if (addEn && !hit) begin
            if (full) begin
                ovfD = 1'b1;
            end else begin
                for (int i = 0; i < MAX_KEYS; i++) begin
                    if (3'(i) == countQ) slotD[i] = code;
                end
                countD = countQ + 3'd1;
            end
        end else if (removeEn && hit) begin
            // Everything at or above the hit slot takes its upper neighbour; top fills with 00.
            for (int i = 0; i < MAX_KEYS; i++) begin
                below = below | hitVec[i];
                if (below) slotD[i] = extSlots[i + 1];
            end
            countD = countQ - 3'd1;
            if (countQ == 3'd1) ovfD = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < MAX_KEYS; i++) slotQ[i] <= 8'h00;
            countQ <= 3'd0;
            ovfQ   <= 1'b0;
        end else begin
            slotQ  <= slotD;
            countQ <= countD;
            ovfQ   <= ovfD;
        end
    end

    assign keyCount = countQ;
    assign keyCode1 = slotQ[0];
    assign keyCode2 = slotQ[1];
    assign overflow = ovfQ;

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 Set-2 make/break prefix decoder feeding the held-key table.
// Optional idle-timeout clear is built when KEY_TIMEOUT_EN is defined.
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int unsigned MAX_KEYS       = 2,
    parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [7:0] scanCode,
    input  logic       scanValid,
    output logic [2:0] keyCount,
    output logic [7:0] keyCode1,
    output logic [7:0] keyCode2,
    output logic       overflow
);

    ps2_rx_state_t stateQ, stateD;
    logic addEn, removeEn, clearEn, expired;

`ifdef KEY_TIMEOUT_EN
    logic [31:0] timerQ, timerD;

    // A byte in the expiry cycle takes priority over the clear.
    assign expired = !scanValid && (timerQ == 32'(TIMEOUT_CYCLES - 1));

    always_comb begin
        timerD = timerQ + 32'd1;
        if (scanValid || expired) timerD = 32'd0;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) timerQ <= 32'd0;
        else          timerQ <= timerD;
    end
`else
    logic unusedTimeout;
    assign unusedTimeout = ^32'(TIMEOUT_CYCLES);
    assign expired       = 1'b0;
`endif

    always_comb begin
        stateD   = stateQ;
        addEn    = 1'b0;
        removeEn = 1'b0;
        clearEn  = 1'b0;
        if (scanValid) begin
            unique case (stateQ)
                IDLE: begin
                    if (scanCode == PS2_BREAK)    stateD = BRK;
                    else if (scanCode == PS2_EXT) stateD = EXT;
                    else if (!isIgnored(scanCode)) addEn = 1'b1;
                end
                BRK: begin
                    if (scanCode == PS2_BREAK)    stateD = BRK;
                    else if (scanCode == PS2_EXT) stateD = EXT_BRK;
                    else begin
                        removeEn = 1'b1;
                        stateD   = IDLE;
                    end
                end
                EXT: begin
                    if (scanCode == PS2_BREAK)    stateD = EXT_BRK;
                    else if (scanCode == PS2_EXT) stateD = EXT;
                    else                          stateD = IDLE;
                end
                EXT_BRK: stateD = IDLE;
            endcase
        end else if (expired) begin
            clearEn = 1'b1;
            stateD  = IDLE;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) stateQ <= IDLE;
        else          stateQ <= stateD;
    end

    key_slot_table #(
        .MAX_KEYS(MAX_KEYS)
    ) uTable (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .addEn    (addEn),
        .removeEn (removeEn),
        .clearEn  (clearEn),
        .code     (scanCode),
        .keyCount (keyCount),
        .keyCode1 (keyCode1),
        .keyCode2 (keyCode2),
        .overflow (overflow)
    );

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench for ps2_key_tracker: each byte pushes its hand-computed expected outputs,
// a monitor compares them one cycle after the strobe.
module tb_ps2_key_tracker;

    typedef struct packed {
        logic [2:0] count;
        logic [7:0] c1;
        logic [7:0] c2;
        logic       ovf;
    } exp_t;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic [7:0] scanCode = 8'h00;
    logic       scanValid = 1'b0;
    logic [2:0] keyCount;
    logic [7:0] keyCode1, keyCode2;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    exp_t expQ[$];
    logic validSeen = 1'b0;

`ifdef KEY_TIMEOUT_EN
    localparam int unsigned Timeout = 16;
`else
    localparam int unsigned Timeout = 50000000;
`endif

    ps2_key_tracker #(
        .MAX_KEYS       (2),
        .TIMEOUT_CYCLES (Timeout)
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .scanCode  (scanCode),
        .scanValid (scanValid),
        .keyCount  (keyCount),
        .keyCode1  (keyCode1),
        .keyCode2  (keyCode2),
        .overflow  (overflow)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) validSeen <= scanValid;

    function automatic exp_t mk(input int cnt, input logic [7:0] a, input logic [7:0] b,
                                input logic o);
        exp_t e;
        e.count = 3'(cnt);
        e.c1    = a;
        e.c2    = b;
        e.ovf   = o;
        return e;
    endfunction

    task automatic compare(input string name, input exp_t e);
        exp_t act;
        act = {keyCount, keyCode1, keyCode2, overflow};
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s: got count=%0d c1=%h c2=%h ovf=%b, want count=%0d c1=%h c2=%h ovf=%b",
                     name, act.count, act.c1, act.c2, act.ovf, e.count, e.c1, e.c2, e.ovf);
        end
    endtask

    // Monitor: outputs reflect the byte accepted on the previous rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (validSeen) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard: output strobe with empty expected queue");
                end else begin
                    e = expQ.pop_front();
                    compare("byte", e);
                end
            end
        end
    end

    // Called at a falling edge; returns at the next falling edge.
    task automatic send(input logic [7:0] c, input exp_t e);
        scanCode  = c;
        scanValid = 1'b1;
        expQ.push_back(e);
        @(negedge Clk);
        scanValid = 1'b0;
    endtask

    task automatic doReset();
        Reset_n = 1'b0;
        #1;
        compare("reset", mk(0, 8'h00, 8'h00, 1'b0));
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
    endtask

    initial begin
        exp_t z;
        z = mk(0, 8'h00, 8'h00, 1'b0);
        @(negedge Clk);
        doReset();

        // Single make.
        send(8'h1D, mk(1, 8'h1D, 8'h00, 1'b0));
        // Fill, overflow, release oldest, then empty clears overflow.
        send(8'h1C, mk(2, 8'h1D, 8'h1C, 1'b0));
        send(8'h1B, mk(2, 8'h1D, 8'h1C, 1'b1));
        send(8'hF0, mk(2, 8'h1D, 8'h1C, 1'b1));
        send(8'h1D, mk(1, 8'h1C, 8'h00, 1'b1));
        send(8'hF0, mk(1, 8'h1C, 8'h00, 1'b1));
        send(8'h1C, z);

        // Typematic repeat and break of a key not held.
        send(8'h1D, mk(1, 8'h1D, 8'h00, 1'b0));
        send(8'h1D, mk(1, 8'h1D, 8'h00, 1'b0));
        send(8'h1D, mk(1, 8'h1D, 8'h00, 1'b0));
        send(8'hF0, mk(1, 8'h1D, 8'h00, 1'b0));
        send(8'h23, mk(1, 8'h1D, 8'h00, 1'b0));
        // Release of the newer key leaves the older in slot 0.
        send(8'h1C, mk(2, 8'h1D, 8'h1C, 1'b0));
        send(8'hF0, mk(2, 8'h1D, 8'h1C, 1'b0));
        send(8'h1C, mk(1, 8'h1D, 8'h00, 1'b0));
        // Repeated F0 stays in break state.
        send(8'hF0, mk(1, 8'h1D, 8'h00, 1'b0));
        send(8'hF0, mk(1, 8'h1D, 8'h00, 1'b0));
        send(8'h1D, z);

        // Extended sequences and ignored bytes change nothing.
        send(8'hE0, z);
        send(8'h75, z);
        send(8'hE0, z);
        send(8'hF0, z);
        send(8'h75, z);
        send(8'hAA, z);
        send(8'hFA, z);
        send(8'h00, z);
        send(8'h23, mk(1, 8'h23, 8'h00, 1'b0));
        send(8'hF0, mk(1, 8'h23, 8'h00, 1'b0));
        send(8'h23, z);

        // Reset discards a pending break prefix.
        send(8'hF0, z);
        doReset();
        send(8'h1C, mk(1, 8'h1C, 8'h00, 1'b0));

`ifdef KEY_TIMEOUT_EN
        doReset();
        send(8'h1D, mk(1, 8'h1D, 8'h00, 1'b0));
        repeat (Timeout - 1) @(negedge Clk);
        compare("before_expiry", mk(1, 8'h1D, 8'h00, 1'b0));
        @(negedge Clk);
        compare("after_expiry", z);
        send(8'h1D, mk(1, 8'h1D, 8'h00, 1'b0));
        repeat (Timeout - 1) @(negedge Clk);
        send(8'h1C, mk(2, 8'h1D, 8'h1C, 1'b0));
        @(negedge Clk);
        compare("strobe_on_expiry", mk(2, 8'h1D, 8'h1C, 1'b0));
`endif

        repeat (3) @(negedge Clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, want 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
